// File: rtl/icache_axi_refill_pkg.sv
// icache_axi_refill_pkg
//   Shared definitions for the instruction-cache AXI refill bridge:
//   FSM state encoding and the AXI4 burst/size/response constants.
//   No ports (package).
package icache_axi_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_AR    = 2'd1,
        ST_R     = 2'd2,
        ST_DRAIN = 2'd3
    } refill_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

endpackage

// File: rtl/icache_refill_perf.sv
// icache_refill_perf
//   Performance counters for the refill bridge. Only instantiated when the
//   ICACHE_REFILL_PERF_EN macro is defined.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   refill_start   - one-cycle strobe on each accepted refill request
//   busy           - high every cycle the bridge is in AR or R
//   perf_refills   - count of accepted refills (wraps at 2^32)
//   perf_cycles    - count of AR+R cycles (wraps at 2^32)
module icache_refill_perf
    import icache_axi_refill_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        refill_start,
    input  logic        busy,
    output logic [31:0] perf_refills,
    output logic [31:0] perf_cycles
);

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_refills <= '0;
            perf_cycles  <= '0;
        end else begin
            if (refill_start) perf_refills <= perf_refills + 32'd1;
            if (busy)         perf_cycles  <= perf_cycles + 32'd1;
        end
    end

endmodule

// File: rtl/icache_axi_refill.sv
// icache_axi_refill
//   Refill bridge between the instruction cache and an AXI4 read port.
//   A cache line request (chaddr/chlen/chburst) becomes either one INCR
//   burst or a sequence of single-beat reads; every returned beat is handed
//   back as a one-cycle chready pulse with chdata. Response, ID and rlast
//   problems raise a one-cycle err alongside the offending beat.
//   Optional: define ICACHE_REFILL_PERF_EN to build the perf counters;
//   otherwise perf_refills/perf_cycles are tied to zero.
// Ports:
//   clock, reset                       - clock, synchronous active-high reset
//   chvalid/chburst/chaddr/chlen       - cache refill request
//   chready/chdata/err                 - per-beat return to the cache
//   arvalid/arready/araddr/arid/arlen/arsize/arburst - AXI AR channel
//   rvalid/rready/rdata/rresp/rlast/rid             - AXI R channel
//   perf_refills/perf_cycles           - optional performance counters
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int RID_VAL = 0,
    parameter int LEN_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             chvalid,
    input  logic             chburst,
    input  logic [31:0]      chaddr,
    input  logic [LEN_W-1:0] chlen,
    output logic             chready,
    output logic [31:0]      chdata,
    output logic             err,
    output logic             arvalid,
    input  logic             arready,
    output logic [31:0]      araddr,
    output logic [ID_W-1:0]  arid,
    output logic [7:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    input  logic             rvalid,
    output logic             rready,
    input  logic [31:0]      rdata,
    input  logic [1:0]       rresp,
    input  logic             rlast,
    input  logic [ID_W-1:0]  rid,
    output logic [31:0]      perf_refills,
    output logic [31:0]      perf_cycles
);

    refill_state_t    state;
    logic [31:0]      cur_addr;
    logic [LEN_W-1:0] len;
    logic             burst;
    // One bit wider than len so len=all-ones yields 2^LEN_W beats without wrap.
    logic [LEN_W:0]   beat_cnt;

    logic beat_fire;
    logic beat_last;
    logic exp_rlast;
    logic beat_err;
    logic early_end;

    assign arid    = ID_W'(RID_VAL);
    assign arsize  = SIZE_4B;
    assign arburst = burst ? BURST_INCR : BURST_FIXED;

    always_comb begin
        beat_fire = rvalid & rready;
        beat_last = (beat_cnt == {1'b0, len});
        // In single-beat mode every AR is its own one-beat transaction,
        // so a well-formed slave marks each beat as last.
        exp_rlast = burst ? beat_last : 1'b1;
        beat_err  = (rresp != RESP_OKAY) | (rid != ID_W'(RID_VAL)) | (rlast != exp_rlast);
        // Slave ended the burst early: stop waiting for the missing beats.
        early_end = burst & rlast & ~beat_last;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            chready  <= 1'b0;
            chdata   <= '0;
            err      <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            araddr   <= '0;
            arlen    <= '0;
            cur_addr <= '0;
            len      <= '0;
            burst    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            chready <= 1'b0;
            err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (chvalid) begin
                        cur_addr <= chaddr;
                        len      <= chlen;
                        burst    <= chburst;
                        beat_cnt <= '0;
                        arvalid  <= 1'b1;
                        araddr   <= chaddr;
                        arlen    <= chburst ? 8'(chlen) : 8'd0;
                        state    <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (beat_fire) begin
                        chready  <= 1'b1;
                        chdata   <= rdata;
                        err      <= beat_err;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_last || early_end) begin
                            rready <= 1'b0;
                            state  <= ST_DRAIN;
                        end else if (!burst) begin
                            rready   <= 1'b0;
                            cur_addr <= cur_addr + 32'd4;
                            araddr   <= cur_addr + 32'd4;
                            arlen    <= 8'd0;
                            arvalid  <= 1'b1;
                            state    <= ST_AR;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Holding here until chvalid falls prevents re-accepting
                    // the request the cache is still asserting.
                    if (!chvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ICACHE_REFILL_PERF_EN
    logic perf_start;
    logic perf_busy;

    assign perf_start = (state == ST_IDLE) && chvalid;
    assign perf_busy  = (state == ST_AR) || (state == ST_R);

    icache_refill_perf u_perf (
        .clock        (clock),
        .reset        (reset),
        .refill_start (perf_start),
        .busy         (perf_busy),
        .perf_refills (perf_refills),
        .perf_cycles  (perf_cycles)
    );
`else
    assign perf_refills = '0;
    assign perf_cycles  = '0;
`endif

endmodule
